// File: rtl/alu4_pkg.sv
// Shared types and widths for the 4-bit shift result buffer.
// Entry layout is {res, z, lost}; the counter width applies to the optional stats counter.
package alu4_pkg;
    localparam int DATA_W = 4;
    localparam int CNT_W  = 8;

    typedef struct packed {
        logic [DATA_W-1:0] res;
        logic              z;
        logic              lost;
    } entry_t;
endpackage

// File: rtl/alu4_shift_flags.sv
// Combinational flag generation for a left-shift result: zero flag from res,
// lost flag set when any bit of op_a that the shift pushed past the MSB was 1.
module alu4_shift_flags
    import alu4_pkg::*;
(
    input  logic [DATA_W-1:0] op_a,
    input  logic [1:0]        sh,
    input  logic [DATA_W-1:0] res,
    output logic              z,
    output logic              lost
);
    logic [DATA_W-1:0] kept_mask;

    always_comb begin
        // Bits of op_a that survive the shift; the complement is what fell off the top.
        kept_mask = {DATA_W{1'b1}} >> sh;
        z         = (res == '0);
        lost      = |(op_a & ~kept_mask);
    end
endmodule

// File: rtl/alu4_shift_result_buf.sv
// Ready/valid FIFO holding {res, z, lost} entries of a 4-bit left-shift stage.
// Optional accepted-transfer counter on out_cnt when ALU4_SHIFT_STATS_EN is defined.
module alu4_shift_result_buf
    import alu4_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] op_a,
    input  logic [1:0]        sh,
    input  logic [DATA_W-1:0] res,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_res,
    output logic              out_z,
    output logic              out_lost
`ifdef ALU4_SHIFT_STATS_EN
    ,
    output logic [CNT_W-1:0]  out_cnt
`endif
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    entry_t            in_entry;
    entry_t            head_entry;
    entry_t            mem_reg [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [OCC_W-1:0]  count_reg;
    logic [OCC_W-1:0]  count_next;
    logic              flag_z;
    logic              flag_lost;
    logic              push;
    logic              pop;

    alu4_shift_flags u_flags (
        .op_a (op_a),
        .sh   (sh),
        .res  (res),
        .z    (flag_z),
        .lost (flag_lost)
    );

    always_comb begin
        in_entry = '{res: res, z: flag_z, lost: flag_lost};
    end

    // Handshake depends only on registered occupancy, never on out_ready.
    assign in_ready   = (count_reg < OCC_W'(DEPTH));
    assign out_valid  = (count_reg != '0);
    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;

    assign head_entry = mem_reg[rd_ptr_reg];
    assign out_res    = head_entry.res;
    assign out_z      = head_entry.z;
    assign out_lost   = head_entry.lost;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (rst) begin
                    mem_reg[gi] <= '0;
                end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                    mem_reg[gi] <= in_entry;
                end
            end
        end
    endgenerate

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + OCC_W'(1);
            2'b01:   count_next = count_reg - OCC_W'(1);
            default: count_next = count_reg;
        endcase
    end

    // DEPTH is a power of two, so pointer overflow is the wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_next;
        end
    end

`ifdef ALU4_SHIFT_STATS_EN
    logic [CNT_W-1:0] stat_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_cnt_reg <= '0;
        end else if (push && (stat_cnt_reg != {CNT_W{1'b1}})) begin
            stat_cnt_reg <= stat_cnt_reg + CNT_W'(1);
        end
    end

    assign out_cnt = stat_cnt_reg;
`endif
endmodule

// File: doc/alu4_shift_result_buf.md
ALU4_SHIFT_RESULT_BUF -- requirements
Module: alu4_shift_result_buf

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: port clk is the clock and port rst is the reset, with no asynchronous reset path.
REQ-002 The block SHALL have parameter DEPTH, default 2, setting the number of FIFO entries; legal values are powers of two, 2 to 8.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  upstream shift result is present this cycle.
REQ-006 in_ready  output  1  the block accepts the upstream result this cycle.
REQ-007 op_a  input  4  operand that was applied to the left-shift stage.
REQ-008 sh  input  2  shift amount that was applied to the left-shift stage.
REQ-009 res  input  4  left-shift result, equal to op_a shifted left by sh and truncated to 4 bits.
REQ-010 out_valid  output  1  the head entry is valid.
REQ-011 out_ready  input  1  the downstream consumer takes the head entry.
REQ-012 out_res  output  4  head entry result.
REQ-013 out_z  output  1  head entry zero flag.
REQ-014 out_lost  output  1  head entry flag, set when nonzero bits were shifted out.
REQ-015 out_cnt  output  8  accepted-result counter; present only under ALU4_SHIFT_STATS_EN.

Function
REQ-016 A transfer SHALL occur on a clk edge where in_valid and in_ready are both high; an entry is {res, z, lost}.
REQ-017 z SHALL be 1 exactly when res is 4'h0.
REQ-018 lost SHALL be 0 when sh is 0; otherwise it SHALL be the OR of op_a[3:4-sh].
REQ-019 Entries SHALL be stored in FIFO order using wrapping read/write pointers and an occupancy count from 0 to DEPTH.
REQ-020 in_ready SHALL equal (count < DEPTH), combinational from registered state only, with no combinational path from out_ready.
REQ-021 out_valid SHALL equal (count != 0); out_res, out_z and out_lost SHALL be driven from the head entry registers, with zero bypass.
REQ-022 Latency from accept to out_valid SHALL be exactly 1 cycle when the FIFO is empty.
REQ-023 Simultaneous push and pop SHALL leave the count unchanged, and SHALL be allowed when the FIFO is full only if in_ready was high that cycle (a full FIFO does not accept, per REQ-020).
REQ-024 out_valid and the head data SHALL stay stable while out_ready is low.
REQ-025 Pointers SHALL wrap from DEPTH-1 to 0 with no lost or duplicated entries.
REQ-026 Input fields SHALL be ignored whenever in_valid is low.

Reset
REQ-027 On rst, the count, pointers, out_valid, out_res, out_z, out_lost and out_cnt SHALL all become 0, and in_ready SHALL become 1 on the next cycle.
REQ-028 Reset asserted mid-stream SHALL discard all stored entries; a push in the same cycle as rst SHALL be dropped.

Configuration
REQ-029 With macro ALU4_SHIFT_STATS_EN defined, out_cnt SHALL increment by 1 on each accepted transfer and saturate at 8'hFF.
REQ-030 Without ALU4_SHIFT_STATS_EN, the out_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-031 A shared package alu4_pkg SHALL hold the entry struct {res[3:0], z, lost}, the data width constant 4 and the counter width constant 8.
REQ-032 Flag generation SHALL reside in one sub-module, alu4_shift_flags (inputs op_a, sh, res; outputs z, lost), which is purely combinational.

Verification
REQ-033 op_a=4'b1011, sh=2, res=4'b1100, then one cycle later out_valid=1, out_res=4'hC, out_z=0, out_lost=1.
REQ-034 op_a=4'b0011, sh=2, res=4'b1100, then out_lost=0; op_a=0, sh=3, res=0, then out_z=1 and out_lost=0.
REQ-035 With out_ready=0 and 3 pushes at DEPTH=2, in_ready=0 after the 2nd push, the 3rd is not accepted, and the head is held stable.
REQ-036 With continuous push and pop for 10 cycles, the output sequence equals the input sequence, the count stays at 1, and the pointers wrap.
REQ-037 rst asserted with 2 entries stored, then the next cycle shows out_valid=0, in_ready=1, and out_cnt=0.
REQ-038 With ALU4_SHIFT_STATS_EN defined, 300 accepted transfers give out_cnt=8'hFF.
